stall_mgmt_ctrl: RTL and testbench
==================================

Name: stall_mgmt_ctrl

Overview:
- Producer-side controller for the single-overflow buffer slot: it drives the buffer's data and stall inputs and watches its overflow indicator (`to_stall_mgmt`).
- It accepts words from an upstream valid/ready source and converts a downstream stall request into a legal stall/drain sequence for the slot.
- It never presents a word that the slot would overwrite or drop.
- It adds a stall watchdog and a protocol cross-check on the overflow indicator.

Parameters:
- DATA_W, 32, word width; matches the buffer data path.
- IDLE_WORD, 32'h0, bubble value driven when no word is issued.
- MAX_STALL, 64, maximum consecutive cycles with buf_stall=1 before a forced release (>=2).
- CNT_W, 16, width of statistics counters.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream word valid.
- in_data  in  DATA_W  upstream word.
- in_ready  out  1  upstream accept; a transfer occurs when in_valid&in_ready.
- stall_req  in  1  downstream request to hold the buffer.
- buf_overflow  in  1  overflow-valid indication from the buffer.
- buf_inputs  out  DATA_W  registered data to the buffer.
- buf_stall  out  1  registered stall to the buffer.
- buf_valid  out  1  registered sideband: buf_inputs carries a real word.
- stall_timeout  out  1  sticky; watchdog fired.
- proto_err  out  1  sticky; buf_overflow disagreed with expected state.
- issued_cnt  out  CNT_W  words accepted (stats).
- stall_cycles  out  CNT_W  cycles with buf_stall=1 (stats).

Behaviour:
- Reset (async, reset_n=0):
  - state=PASS; buf_stall=0; buf_inputs=IDLE_WORD; buf_valid=0.
  - stall_timeout=0; proto_err=0; all counters=0; parked register=IDLE_WORD.
- Slot rules the FSM must respect:
  - Any cycle with stall=1 writes buf_inputs into the overflow slot and sets overflow valid.
  - The first cycle with stall=0 afterwards emits the overflow word and ignores buf_inputs.
- rel = !stall_req | wd_hit, where wd_hit = (stall_cnt == MAX_STALL-1) while buf_stall=1.
- in_ready = (state==PASS) | (state==STALL_OPEN & !rel). It is 0 in STALL_FULL and DRAIN.
- States and next-registered outputs; acc = in_valid & in_ready:
  - PASS:
    - stall_req=0: buf_stall<=0; buf_inputs<=acc?in_data:IDLE_WORD; buf_valid<=acc.
    - stall_req=1 & acc: buf_stall<=1; buf_inputs<=in_data; parked<=in_data; buf_valid<=1; go STALL_FULL.
    - stall_req=1 & !acc: buf_stall<=1; buf_inputs<=IDLE_WORD; buf_valid<=0; go STALL_OPEN.
  - STALL_OPEN: at most one word may still be parked.
    - rel=1: buf_stall<=0; go DRAIN. The slot drains IDLE_WORD.
    - else acc: buf_inputs<=in_data; parked<=in_data; buf_valid<=1; go STALL_FULL.
    - else: hold IDLE_WORD.
  - STALL_FULL:
    - buf_inputs<=parked; buf_valid<=0. Rewriting the same value is harmless.
    - rel=1: buf_stall<=0; go DRAIN.
  - DRAIN: buf_stall=0 and the slot drains this cycle. buf_inputs<=IDLE_WORD; buf_valid<=0; go PASS unconditionally.
- A stall_req re-assertion during DRAIN is honoured from PASS next cycle. Minimum stall episode is 3 cycles: enter, 1 stall cycle, DRAIN.
- Watchdog:
  - stall_cnt increments while buf_stall=1 and clears when buf_stall=0.
  - wd_hit forces release and sets stall_timeout.
  - A still-asserted stall_req after DRAIN re-enters the stall normally.
- Protocol check: proto_err<=1 if (state==PASS & buf_overflow) or (state==DRAIN & !buf_overflow).
- Latency: an accepted word appears on buf_inputs 1 cycle later and on the buffer output 2 cycles later. A parked word appears on the buffer output at the end of DRAIN.
- Counters: issued_cnt counts acc; stall_cycles counts buf_stall=1. Both wrap at 2^CNT_W.
- Reset mid-stall: returns to PASS with buf_stall=0. The buffer shares the reset, so no drain is owed.

Optional Feature:
- STALL_MGMT_STATS_EN defined: issued_cnt and stall_cycles are implemented as described.
- Undefined: both outputs are tied to 0 and the counter registers are removed. The watchdog stall_cnt is always present.

Test Plan:
- Streaming: stall_req=0, words 0x11,0x22,0x33 on consecutive cycles -> buf_inputs shows 0x11,0x22,0x33 one cycle later with buf_valid=1 and buf_stall=0; issued_cnt=3.
- Stall with word: at PASS, stall_req=1 and in_data=0xA5A5_0001 accepted -> buf_stall=1 and buf_inputs=0xA5A5_0001 next cycle; in_ready=0 while stalled; stall_req drop -> DRAIN with buf_overflow=1, then PASS; proto_err=0.
- Stall without word: stall_req=1 for 5 cycles with in_valid=0, then one word 0x77 -> state STALL_FULL, parked=0x77; release -> buffer emits 0x77 at DRAIN end; no second word accepted during the stall.
- Watchdog: MAX_STALL=8, stall_req held high 20 cycles -> buf_stall drops after 8 stall cycles; stall_timeout=1; DRAIN then re-stall.
- Protocol error: force buf_overflow=1 while in PASS -> proto_err=1 next cycle and stays set until reset_n=0.
- Async reset in STALL_FULL: pulse reset_n low mid-cycle -> buf_stall=0, buf_inputs=0, flags and counters 0 immediately; in_ready=1 after release.

Source files
------------

// File: rtl/stall_mgmt_ctrl_if.sv
// stall_mgmt_ctrl_if: upstream valid/ready pair, downstream stall request and
// the producer-side signals of the single-overflow buffer slot.
// master = controller side, slave = environment (source, sink, buffer).
interface stall_mgmt_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              stall_req;
    logic              buf_overflow;
    logic [DATA_W-1:0] buf_inputs;
    logic              buf_stall;
    logic              buf_valid;

    modport master (
        input  in_valid, in_data, stall_req, buf_overflow,
        output in_ready, buf_inputs, buf_stall, buf_valid
    );

    modport slave (
        output in_valid, in_data, stall_req, buf_overflow,
        input  in_ready, buf_inputs, buf_stall, buf_valid
    );
endinterface

// File: rtl/stall_mgmt_ctrl.sv
// stall_mgmt_ctrl: producer-side controller for a single-overflow buffer slot.
// Turns a downstream stall request into a legal stall/drain sequence so that
// no word is ever overwritten in, or dropped by, the overflow slot. Includes a
// stall watchdog and a cross-check of the slot's overflow indicator.
// Optional feature macro: STALL_MGMT_STATS_EN enables the issued_cnt and
// stall_cycles statistics counters; when undefined both read as zero.
module stall_mgmt_ctrl #(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] IDLE_WORD = 32'h0,
    parameter int                MAX_STALL = 64,
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    stall_mgmt_ctrl_if.master bus,
    output logic              stall_timeout,
    output logic              proto_err,
    output logic [CNT_W-1:0]  issued_cnt,
    output logic [CNT_W-1:0]  stall_cycles
);

    typedef enum logic [1:0] {
        PASS       = 2'd0,
        STALL_OPEN = 2'd1,
        STALL_FULL = 2'd2,
        DRAIN      = 2'd3
    } state_t;

    // stall_cnt never exceeds MAX_STALL-1: the watchdog releases at that value
    localparam int              SC_W    = $clog2(MAX_STALL);
    localparam logic [SC_W-1:0] WD_LAST = SC_W'(MAX_STALL - 1);

    state_t            state_r;
    state_t            state_nxt_s;
    logic [DATA_W-1:0] buf_inputs_r;
    logic [DATA_W-1:0] buf_inputs_nxt_s;
    logic [DATA_W-1:0] parked_r;
    logic [DATA_W-1:0] parked_nxt_s;
    logic              buf_stall_r;
    logic              buf_stall_nxt_s;
    logic              buf_valid_r;
    logic              buf_valid_nxt_s;
    logic [SC_W-1:0]   stall_cnt_r;
    logic              stall_timeout_r;
    logic              proto_err_r;
    logic              wd_hit_s;
    logic              rel_s;
    logic              in_ready_s;
    logic              acc_s;
    logic              proto_bad_s;

    assign wd_hit_s    = buf_stall_r & (stall_cnt_r == WD_LAST);
    assign rel_s       = ~bus.stall_req | wd_hit_s;
    // STALL_OPEN may still take the one word the slot can hold, unless releasing
    assign in_ready_s  = (state_r == PASS) | ((state_r == STALL_OPEN) & ~rel_s);
    assign acc_s       = bus.in_valid & in_ready_s;
    // After DRAIN the slot must be empty; in DRAIN it must still hold a word
    assign proto_bad_s = ((state_r == PASS) & bus.buf_overflow) |
                         ((state_r == DRAIN) & ~bus.buf_overflow);

    // State register together with the registered buffer-facing outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= PASS;
            buf_stall_r  <= 1'b0;
            buf_inputs_r <= IDLE_WORD;
            buf_valid_r  <= 1'b0;
            parked_r     <= IDLE_WORD;
        end else begin
            state_r      <= state_nxt_s;
            buf_stall_r  <= buf_stall_nxt_s;
            buf_inputs_r <= buf_inputs_nxt_s;
            buf_valid_r  <= buf_valid_nxt_s;
            parked_r     <= parked_nxt_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            PASS: begin
                if (bus.stall_req) begin
                    if (acc_s) begin
                        state_nxt_s = STALL_FULL;
                    end else begin
                        state_nxt_s = STALL_OPEN;
                    end
                end else begin
                    state_nxt_s = PASS;
                end
            end
            STALL_OPEN: begin
                if (rel_s) begin
                    state_nxt_s = DRAIN;
                end else if (acc_s) begin
                    state_nxt_s = STALL_FULL;
                end else begin
                    state_nxt_s = STALL_OPEN;
                end
            end
            STALL_FULL: begin
                if (rel_s) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = STALL_FULL;
                end
            end
            DRAIN:   state_nxt_s = PASS;
            default: state_nxt_s = PASS;
        endcase
    end

    // Next values of the buffer-facing outputs and the parked word
    always_comb begin
        buf_stall_nxt_s  = 1'b0;
        buf_inputs_nxt_s = IDLE_WORD;
        buf_valid_nxt_s  = 1'b0;
        parked_nxt_s     = parked_r;
        case (state_r)
            PASS: begin
                buf_stall_nxt_s = bus.stall_req;
                if (acc_s) begin
                    buf_inputs_nxt_s = bus.in_data;
                    buf_valid_nxt_s  = 1'b1;
                    if (bus.stall_req) begin
                        parked_nxt_s = bus.in_data;
                    end else begin
                        parked_nxt_s = parked_r;
                    end
                end else begin
                    buf_inputs_nxt_s = IDLE_WORD;
                    buf_valid_nxt_s  = 1'b0;
                end
            end
            STALL_OPEN: begin
                if (rel_s) begin
                    buf_stall_nxt_s = 1'b0;
                end else if (acc_s) begin
                    buf_stall_nxt_s  = 1'b1;
                    buf_inputs_nxt_s = bus.in_data;
                    buf_valid_nxt_s  = 1'b1;
                    parked_nxt_s     = bus.in_data;
                end else begin
                    buf_stall_nxt_s = 1'b1;
                end
            end
            STALL_FULL: begin
                // Rewriting the parked word keeps the slot content unchanged
                buf_inputs_nxt_s = parked_r;
                buf_stall_nxt_s  = ~rel_s;
            end
            DRAIN: begin
                buf_stall_nxt_s = 1'b0;
            end
            default: begin
                buf_stall_nxt_s = 1'b0;
            end
        endcase
    end

    // Watchdog: length of the current stall run, cleared whenever unstalled
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_r <= {SC_W{1'b0}};
        end else if (buf_stall_r) begin
            stall_cnt_r <= stall_cnt_r + SC_W'(1);
        end else begin
            stall_cnt_r <= {SC_W{1'b0}};
        end
    end

    // Sticky watchdog and protocol flags, cleared only by reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_timeout_r <= 1'b0;
            proto_err_r     <= 1'b0;
        end else begin
            stall_timeout_r <= stall_timeout_r | wd_hit_s;
            proto_err_r     <= proto_err_r | proto_bad_s;
        end
    end

`ifdef STALL_MGMT_STATS_EN
    logic [CNT_W-1:0] issued_cnt_r;
    logic [CNT_W-1:0] stall_cycles_r;

    // Statistics: accepted words and stalled cycles, both wrapping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            issued_cnt_r   <= {CNT_W{1'b0}};
            stall_cycles_r <= {CNT_W{1'b0}};
        end else begin
            if (acc_s) begin
                issued_cnt_r <= issued_cnt_r + CNT_W'(1);
            end
            if (buf_stall_r) begin
                stall_cycles_r <= stall_cycles_r + CNT_W'(1);
            end
        end
    end

    assign issued_cnt   = issued_cnt_r;
    assign stall_cycles = stall_cycles_r;
`else
    assign issued_cnt   = {CNT_W{1'b0}};
    assign stall_cycles = {CNT_W{1'b0}};
`endif

    assign bus.in_ready   = in_ready_s;
    assign bus.buf_inputs = buf_inputs_r;
    assign bus.buf_stall  = buf_stall_r;
    assign bus.buf_valid  = buf_valid_r;
    assign stall_timeout  = stall_timeout_r;
    assign proto_err      = proto_err_r;

endmodule

// File: tb/tb_stall_mgmt_ctrl.sv
// tb_stall_mgmt_ctrl: directed scenarios plus a randomized run against a
// behavioural model of the overflow slot and a word scoreboard.
`timescale 1ns/1ps
module tb_stall_mgmt_ctrl;
    localparam int DATA_W    = 32;
    localparam int MAX_STALL = 8;
    localparam int CNT_W     = 16;
`ifdef STALL_MGMT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic              clk     = 1'b0;
    logic              reset_n = 1'b0;
    logic              stall_timeout;
    logic              proto_err;
    logic [CNT_W-1:0]  issued_cnt;
    logic [CNT_W-1:0]  stall_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    stall_mgmt_ctrl_if #(.DATA_W(DATA_W)) bus();

    stall_mgmt_ctrl #(
        .DATA_W(DATA_W), .IDLE_WORD(32'h0), .MAX_STALL(MAX_STALL), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus),
        .stall_timeout(stall_timeout), .proto_err(proto_err),
        .issued_cnt(issued_cnt), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    // Buffer slot model: stall writes the slot, the first unstalled cycle
    // emits the slot word instead of buf_inputs.
    logic              ov_valid  = 1'b0;
    logic              slot_real = 1'b0;
    logic [DATA_W-1:0] slot_word = '0;
    logic              ovf_force = 1'b0;
    int                overwrite_cnt = 0;
    int                drop_cnt      = 0;
    logic [DATA_W-1:0] emit_q[$];

    assign bus.buf_overflow = ov_valid | ovf_force;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ov_valid  <= 1'b0;
            slot_real <= 1'b0;
            slot_word <= '0;
        end else if (bus.buf_stall) begin
            ov_valid <= 1'b1;
            if (bus.buf_valid) begin
                if (slot_real) overwrite_cnt <= overwrite_cnt + 1;
                slot_real <= 1'b1;
                slot_word <= bus.buf_inputs;
            end else if (slot_real) begin
                if (bus.buf_inputs !== slot_word) overwrite_cnt <= overwrite_cnt + 1;
            end else begin
                slot_word <= bus.buf_inputs;
            end
        end else begin
            ov_valid  <= 1'b0;
            slot_real <= 1'b0;
            if (ov_valid) begin
                if (slot_real) emit_q.push_back(slot_word);
                if (bus.buf_valid) drop_cnt <= drop_cnt + 1;
            end else if (bus.buf_valid) begin
                emit_q.push_back(bus.buf_inputs);
            end
        end
    end

    function automatic logic [CNT_W-1:0] exp_stat(input int n);
        return STATS ? CNT_W'(n) : {CNT_W{1'b0}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0; bus.in_data = '0; bus.stall_req = 1'b0; ovf_force = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        tick();
        emit_q.delete();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.stall_req = 1'b0; ovf_force = 1'b0;
        #12;
        n_checks++; if (bus.buf_stall !== 1'b0) begin n_fail++; $display("FAIL reset_buf_stall: got %0b want 0", bus.buf_stall); end
        n_checks++; if (bus.buf_inputs !== 32'h0) begin n_fail++; $display("FAIL reset_buf_inputs: got %h want 0", bus.buf_inputs); end
        n_checks++; if (bus.buf_valid !== 1'b0) begin n_fail++; $display("FAIL reset_buf_valid: got %0b want 0", bus.buf_valid); end
        n_checks++; if (stall_timeout !== 1'b0 || proto_err !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got %0b%0b want 00", stall_timeout, proto_err); end
        n_checks++; if (issued_cnt !== 16'h0 || stall_cycles !== 16'h0) begin n_fail++; $display("FAIL reset_counters: got %h/%h want 0/0", issued_cnt, stall_cycles); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 1", bus.in_ready); end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_streaming();
        logic [DATA_W-1:0] w[3];
        w = '{32'h11, 32'h22, 32'h33};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1; bus.in_data = w[i];
            tick();
            n_checks++; if (bus.buf_inputs !== w[i] || bus.buf_valid !== 1'b1 || bus.buf_stall !== 1'b0) begin
                n_fail++; $display("FAIL stream_word%0d: got %h v%0b s%0b want %h v1 s0", i, bus.buf_inputs, bus.buf_valid, bus.buf_stall, w[i]); end
        end
        bus.in_valid = 1'b0;
        tick();
        n_checks++; if (bus.buf_valid !== 1'b0) begin n_fail++; $display("FAIL stream_bubble: got v%0b want v0", bus.buf_valid); end
        tick();
        n_checks++; if (emit_q.size() != 3) begin n_fail++; $display("FAIL stream_emit_count: got %0d want 3", emit_q.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++; if (emit_q[i] !== w[i]) begin n_fail++; $display("FAIL stream_emit%0d: got %h want %h", i, emit_q[i], w[i]); end
            end
        end
        n_checks++; if (issued_cnt !== exp_stat(3)) begin n_fail++; $display("FAIL stream_issued: got %0d want %0d", issued_cnt, exp_stat(3)); end
    endtask

    task automatic test_stall_word();
        do_reset();
        bus.stall_req = 1'b1; bus.in_valid = 1'b1; bus.in_data = 32'hA5A5_0001;
        #1;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL sw_ready_pass: got %0b want 1", bus.in_ready); end
        tick();
        n_checks++; if (bus.buf_stall !== 1'b1 || bus.buf_inputs !== 32'hA5A5_0001 || bus.buf_valid !== 1'b1) begin
            n_fail++; $display("FAIL sw_enter: got s%0b %h v%0b want s1 a5a50001 v1", bus.buf_stall, bus.buf_inputs, bus.buf_valid); end
        bus.in_data = 32'hDEAD_BEEF;
        #1;
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL sw_ready_full: got %0b want 0", bus.in_ready); end
        tick();
        n_checks++; if (bus.buf_stall !== 1'b1 || bus.buf_inputs !== 32'hA5A5_0001 || bus.buf_valid !== 1'b0) begin
            n_fail++; $display("FAIL sw_hold: got s%0b %h v%0b want s1 a5a50001 v0", bus.buf_stall, bus.buf_inputs, bus.buf_valid); end
        bus.stall_req = 1'b0; bus.in_valid = 1'b0;
        tick();
        n_checks++; if (bus.buf_stall !== 1'b0 || bus.buf_overflow !== 1'b1 || bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL sw_drain: got s%0b ov%0b r%0b want s0 ov1 r0", bus.buf_stall, bus.buf_overflow, bus.in_ready); end
        tick();
        n_checks++; if (emit_q.size() != 1 || emit_q[0] !== 32'hA5A5_0001) begin n_fail++; $display("FAIL sw_emit: got %0d words want a5a50001", emit_q.size()); end
        n_checks++; if (bus.in_ready !== 1'b1 || proto_err !== 1'b0) begin n_fail++; $display("FAIL sw_pass: got r%0b pe%0b want r1 pe0", bus.in_ready, proto_err); end
        n_checks++; if (issued_cnt !== exp_stat(1) || stall_cycles !== exp_stat(2)) begin
            n_fail++; $display("FAIL sw_stats: got %0d/%0d want %0d/%0d", issued_cnt, stall_cycles, exp_stat(1), exp_stat(2)); end
    endtask

    task automatic test_stall_no_word();
        do_reset();
        bus.stall_req = 1'b1; bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        n_checks++; if (bus.buf_stall !== 1'b1 || bus.buf_valid !== 1'b0) begin n_fail++; $display("FAIL snw_open: got s%0b v%0b want s1 v0", bus.buf_stall, bus.buf_valid); end
        bus.in_valid = 1'b1; bus.in_data = 32'h77;
        #1;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL snw_ready_open: got %0b want 1", bus.in_ready); end
        tick();
        n_checks++; if (bus.buf_inputs !== 32'h77 || bus.buf_valid !== 1'b1 || bus.buf_stall !== 1'b1) begin
            n_fail++; $display("FAIL snw_park: got %h v%0b s%0b want 77 v1 s1", bus.buf_inputs, bus.buf_valid, bus.buf_stall); end
        bus.in_data = 32'h88;
        #1;
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL snw_ready_full: got %0b want 0", bus.in_ready); end
        tick();
        n_checks++; if (bus.buf_inputs !== 32'h77) begin n_fail++; $display("FAIL snw_parked: got %h want 77", bus.buf_inputs); end
        bus.stall_req = 1'b0;
        tick();
        n_checks++; if (bus.in_ready !== 1'b0 || bus.buf_stall !== 1'b0) begin n_fail++; $display("FAIL snw_drain: got r%0b s%0b want r0 s0", bus.in_ready, bus.buf_stall); end
        bus.in_valid = 1'b0;
        tick();
        n_checks++; if (emit_q.size() != 1 || emit_q[0] !== 32'h77) begin n_fail++; $display("FAIL snw_emit: got %0d words want one 77", emit_q.size()); end
        n_checks++; if (issued_cnt !== exp_stat(1) || stall_timeout !== 1'b0) begin
            n_fail++; $display("FAIL snw_issued: got %0d to%0b want %0d to0", issued_cnt, stall_timeout, exp_stat(1)); end
    endtask

    task automatic test_watchdog();
        int exp_sc;
        bit exp_st;
        bit exp_to;
        do_reset();
        exp_sc = 0;
        bus.stall_req = 1'b1; bus.in_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            exp_st = ((k - 1) % (MAX_STALL + 2)) < MAX_STALL;
            exp_to = (k >= MAX_STALL + 1);
            n_checks++; if (bus.buf_stall !== exp_st) begin n_fail++; $display("FAIL wd_stall_c%0d: got %0b want %0b", k, bus.buf_stall, exp_st); end
            n_checks++; if (stall_timeout !== exp_to) begin n_fail++; $display("FAIL wd_timeout_c%0d: got %0b want %0b", k, stall_timeout, exp_to); end
            n_checks++; if (stall_cycles !== exp_stat(exp_sc)) begin n_fail++; $display("FAIL wd_cycles_c%0d: got %0d want %0d", k, stall_cycles, exp_stat(exp_sc)); end
            if (exp_st) exp_sc++;
        end
        bus.stall_req = 1'b0;
        n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL wd_proto: got %0b want 0", proto_err); end
    endtask

    task automatic test_protocol();
        do_reset();
        ovf_force = 1'b1;
        tick();
        n_checks++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL pe_set: got %0b want 1", proto_err); end
        ovf_force = 1'b0;
        tick(); tick();
        n_checks++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL pe_sticky: got %0b want 1", proto_err); end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL pe_reset: got %0b want 0", proto_err); end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.stall_req = 1'b1; bus.in_valid = 1'b1; bus.in_data = 32'h5A;
        tick();
        bus.in_valid = 1'b0;
        tick();
        n_checks++; if (bus.buf_stall !== 1'b1 || bus.buf_inputs !== 32'h5A) begin n_fail++; $display("FAIL ar_pre: got s%0b %h want s1 5a", bus.buf_stall, bus.buf_inputs); end
        #3;
        reset_n = 1'b0;
        #1;
        n_checks++; if (bus.buf_stall !== 1'b0 || bus.buf_inputs !== 32'h0 || bus.buf_valid !== 1'b0) begin
            n_fail++; $display("FAIL ar_outputs: got s%0b %h v%0b want s0 0 v0", bus.buf_stall, bus.buf_inputs, bus.buf_valid); end
        n_checks++; if (stall_timeout !== 1'b0 || proto_err !== 1'b0 || issued_cnt !== 16'h0 || stall_cycles !== 16'h0) begin
            n_fail++; $display("FAIL ar_flags_counters: got %0b %0b %0d %0d want 0 0 0 0", stall_timeout, proto_err, issued_cnt, stall_cycles); end
        @(negedge clk);
        reset_n = 1'b1; bus.stall_req = 1'b0;
        #1;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL ar_ready: got %0b want 1", bus.in_ready); end
        tick();
        n_checks++; if (bus.buf_stall !== 1'b0 || proto_err !== 1'b0) begin n_fail++; $display("FAIL ar_after: got s%0b pe%0b want s0 pe0", bus.buf_stall, proto_err); end
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] exp_q[$];
        logic [DATA_W-1:0] e;
        logic [DATA_W-1:0] d;
        int  run;
        int  n_acc;
        int  n_sc;
        bit  prev_stall;
        bit  exp_to;
        bit  exp_rdy;
        do_reset();
        run = 0; n_acc = 0; n_sc = 0; prev_stall = 1'b0; exp_to = 1'b0;
        for (int c = 0; c < 3012; c++) begin
            if (c >= 3000) begin
                bus.stall_req = 1'b0; bus.in_valid = 1'b0;
            end else begin
                if ($urandom_range(0, 5) == 0) bus.stall_req = ~bus.stall_req;
                bus.in_valid = ($urandom_range(0, 9) < 7);
            end
            bus.in_data = $urandom;
            #1;
            // Unstalled: ready in pass-through, not in the drain cycle.
            // Stalled: ready only if nothing held and no release this cycle.
            if (!bus.buf_stall) exp_rdy = !prev_stall;
            else exp_rdy = !(slot_real || bus.buf_valid) && bus.stall_req && (run != MAX_STALL);
            n_checks++; if (bus.in_ready !== exp_rdy) begin n_fail++; $display("FAIL rand_ready_c%0d: got %0b want %0b", c, bus.in_ready, exp_rdy); end
            if (bus.in_valid && bus.in_ready) begin exp_q.push_back(bus.in_data); n_acc++; end
            if (bus.buf_stall) n_sc++;
            prev_stall = bus.buf_stall;
            if (run == MAX_STALL) exp_to = 1'b1;
            tick();
            while (emit_q.size() > 0) begin
                e = emit_q.pop_front();
                n_checks++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL rand_emit_c%0d: got %h want no word", c, e); end
                else begin
                    d = exp_q.pop_front();
                    if (e !== d) begin n_fail++; $display("FAIL rand_emit_c%0d: got %h want %h", c, e, d); end
                end
            end
            run = bus.buf_stall ? run + 1 : 0;
            n_checks++; if (run > MAX_STALL) begin n_fail++; $display("FAIL rand_stall_run_c%0d: got %0d want <=%0d", c, run, MAX_STALL); end
            n_checks++; if (stall_timeout !== exp_to) begin n_fail++; $display("FAIL rand_timeout_c%0d: got %0b want %0b", c, stall_timeout, exp_to); end
            n_checks++; if (issued_cnt !== exp_stat(n_acc) || stall_cycles !== exp_stat(n_sc)) begin
                n_fail++; $display("FAIL rand_stats_c%0d: got %0d/%0d want %0d/%0d", c, issued_cnt, stall_cycles, exp_stat(n_acc), exp_stat(n_sc)); end
            n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL rand_proto_c%0d: got %0b want 0", c, proto_err); end
        end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_lost_words: got %0d outstanding want 0", exp_q.size()); end
        n_checks++; if (overwrite_cnt != 0 || drop_cnt != 0) begin n_fail++; $display("FAIL rand_slot_integrity: got %0d overwrites %0d drops want 0 0", overwrite_cnt, drop_cnt); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_stall_word();
        test_stall_no_word();
        test_watchdog();
        test_protocol();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
